// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 WSAD/arrow-key decoder.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } state_t;

   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_E0    = 8'hE0;
   localparam logic [7:0] SC_F0    = 8'hF0;
   localparam logic [7:0] SC_AA    = 8'hAA;

   localparam logic [1:0] KEY_W = 2'd3;
   localparam logic [1:0] KEY_S = 2'd2;
   localparam logic [1:0] KEY_A = 2'd1;
   localparam logic [1:0] KEY_D = 2'd0;

   typedef struct packed {
      logic       hit;
      logic [1:0] idx;
   } key_map_t;

   function automatic key_map_t map_plain(input logic [7:0] c);
      key_map_t m;
      m = '0;
      case (c)
         SC_W: begin m.hit = 1'b1; m.idx = KEY_W; end
         SC_S: begin m.hit = 1'b1; m.idx = KEY_S; end
         SC_A: begin m.hit = 1'b1; m.idx = KEY_A; end
         SC_D: begin m.hit = 1'b1; m.idx = KEY_D; end
         default: m = '0;
      endcase
      return m;
   endfunction

   // Arrow keys alias onto the same four bits as WSAD.
   function automatic key_map_t map_ext(input logic [7:0] c);
      key_map_t m;
      m = '0;
      case (c)
         SC_UP:    begin m.hit = 1'b1; m.idx = KEY_W; end
         SC_DOWN:  begin m.hit = 1'b1; m.idx = KEY_S; end
         SC_LEFT:  begin m.hit = 1'b1; m.idx = KEY_A; end
         SC_RIGHT: begin m.hit = 1'b1; m.idx = KEY_D; end
         default:  m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ps2_wsad_decoder_if.sv
// Keyboard-side bus and decoded outputs of the PS/2 WSAD decoder.
interface ps2_wsad_decoder_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [3:0] wsad_down;
   logic [7:0] code;
   logic       code_valid;
   logic       frame_err;

   modport master (output ps2_clk, ps2_data,
                   input  wsad_down, code, code_valid, frame_err);
   modport slave  (input  ps2_clk, ps2_data,
                   output wsad_down, code, code_valid, frame_err);
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, 11-bit deframing, parity.
// Optional partial-frame timeout is built only when PS2_TIMEOUT_EN is defined.
module ps2_rx_frame #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic [7:0] o_code,
   output logic       o_code_valid,
   output logic       o_frame_err
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   logic       r_clk_s1, r_clk_s2, r_clk_s3;
   logic       r_dat_s1, r_dat_s2;
   logic [3:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic       r_par;
   logic [7:0] r_code;
   logic       r_code_valid;
   logic       r_frame_err;
   logic       w_fall;
   logic       w_timeout;

   assign w_fall = r_clk_s3 & ~r_clk_s2;

`ifdef PS2_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_to_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            r_to_cnt <= '0;
      else if (w_fall || r_bit_cnt == 4'd0) r_to_cnt <= '0;
      else                                r_to_cnt <= r_to_cnt + 1'b1;
   end

   assign w_timeout = (r_bit_cnt != 4'd0) && !w_fall &&
                      (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // Synchronizers reset high so an idle bus does not look like a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_s1     <= 1'b1;
         r_clk_s2     <= 1'b1;
         r_clk_s3     <= 1'b1;
         r_dat_s1     <= 1'b1;
         r_dat_s2     <= 1'b1;
         r_bit_cnt    <= 4'd0;
         r_shift      <= 8'd0;
         r_par        <= 1'b0;
         r_code       <= 8'd0;
         r_code_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_clk_s1     <= i_ps2_clk;
         r_clk_s2     <= r_clk_s1;
         r_clk_s3     <= r_clk_s2;
         r_dat_s1     <= i_ps2_data;
         r_dat_s2     <= r_dat_s1;
         r_code_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         if (w_timeout) begin
            r_bit_cnt   <= 4'd0;
            r_frame_err <= 1'b1;
         end else if (w_fall) begin
            case (r_bit_cnt)
               4'd0: if (!r_dat_s2) r_bit_cnt <= 4'd1;
               4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                  r_shift   <= {r_dat_s2, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 4'd1;
               end
               4'd9: begin
                  r_par     <= r_dat_s2;
                  r_bit_cnt <= 4'd10;
               end
               default: begin
                  if ((^{r_shift, r_par}) && r_dat_s2) begin
                     r_code       <= r_shift;
                     r_code_valid <= 1'b1;
                  end else begin
                     r_frame_err  <= 1'b1;
                  end
                  r_bit_cnt <= 4'd0;
               end
            endcase
         end
      end
   end

   assign o_code       = r_code;
   assign o_code_valid = r_code_valid;
   assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_wsad_decoder.sv
// PS/2 keyboard decoder tracking held state of W/S/A/D and the arrow keys.
// Build with PS2_TIMEOUT_EN defined to discard stalled partial frames.
module ps2_wsad_decoder
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic               clk,
   input  logic               rst,
   ps2_wsad_decoder_if.slave  bus
);

   logic [7:0] w_code;
   logic       w_code_valid;
   logic       w_frame_err;
   state_t     r_state, w_state_nxt;
   logic [3:0] r_wsad, w_wsad_nxt;
   key_map_t   w_mp, w_me;

   ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk          (clk),
      .rst          (rst),
      .i_ps2_clk    (bus.ps2_clk),
      .i_ps2_data   (bus.ps2_data),
      .o_code       (w_code),
      .o_code_valid (w_code_valid),
      .o_frame_err  (w_frame_err)
   );

   assign w_mp = map_plain(w_code);
   assign w_me = map_ext(w_code);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_wsad  <= 4'b0000;
      end else begin
         r_state <= w_state_nxt;
         r_wsad  <= w_wsad_nxt;
      end
   end

   // BAT-pass (AA) wipes key state regardless of any pending prefix.
   always_comb begin
      w_state_nxt = r_state;
      w_wsad_nxt  = r_wsad;
      if (w_frame_err) begin
         w_state_nxt = ST_IDLE;
      end else if (w_code_valid) begin
         if (w_code == SC_AA) begin
            w_wsad_nxt  = 4'b0000;
            w_state_nxt = ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_code == SC_E0)      w_state_nxt = ST_EXT;
                  else if (w_code == SC_F0) w_state_nxt = ST_BRK;
                  else if (w_mp.hit)        w_wsad_nxt[w_mp.idx] = 1'b1;
               end
               ST_EXT: begin
                  if (w_code == SC_F0) begin
                     w_state_nxt = ST_EXT_BRK;
                  end else begin
                     if (w_me.hit) w_wsad_nxt[w_me.idx] = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end
               end
               ST_BRK: begin
                  if (w_mp.hit) w_wsad_nxt[w_mp.idx] = 1'b0;
                  w_state_nxt = ST_IDLE;
               end
               default: begin
                  if (w_me.hit) w_wsad_nxt[w_me.idx] = 1'b0;
                  w_state_nxt = ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.wsad_down  = r_wsad;
   assign bus.code       = w_code;
   assign bus.code_valid = w_code_valid;
   assign bus.frame_err  = w_frame_err;

endmodule

// File: tb/tb_ps2_wsad_decoder.sv
// Directed + random bench for ps2_wsad_decoder against a byte-sequence key model.
module tb_ps2_wsad_decoder;

   localparam int TO = 2000;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;
   int   n_valid;
   int   n_err;
   int   since_cv;
   logic [3:0] prev_wsad;

   logic [3:0] m_wsad;
   logic [7:0] m_code;
   logic [7:0] m_pend[$];

   ps2_wsad_decoder_if bus ();

   ps2_wsad_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Key state may only move on the cycle right after a code_valid pulse.
   always @(negedge clk) begin
      if (rst) begin
         prev_wsad = 4'b0000;
         since_cv  = 99;
      end else begin
         if (since_cv < 99) since_cv++;
         if (bus.wsad_down !== prev_wsad) begin
            n_assert++;
            assert (since_cv == 1) else begin
               n_fail++;
               $error("FAIL wsad_timing: observed %0d cycles after code_valid expected 1", since_cv);
            end
         end
         prev_wsad = bus.wsad_down;
         if (bus.code_valid === 1'b1) begin
            since_cv = 0;
            n_valid++;
         end
         if (bus.frame_err === 1'b1) n_err++;
      end
   end

   function automatic int key_idx(input logic [7:0] c, input bit ext);
      if (!ext) begin
         if (c == 8'h1D) return 3;
         if (c == 8'h1B) return 2;
         if (c == 8'h1C) return 1;
         if (c == 8'h23) return 0;
      end else begin
         if (c == 8'h75) return 3;
         if (c == 8'h72) return 2;
         if (c == 8'h6B) return 1;
         if (c == 8'h74) return 0;
      end
      return -1;
   endfunction

   // Prefix bytes accumulate until a terminating byte resolves the sequence.
   task automatic model_byte(input logic [7:0] b);
      bit ext, brk;
      int idx;
      m_code = b;
      if (b == 8'hAA) begin
         m_wsad = 4'b0000;
         m_pend.delete();
      end else if (m_pend.size() == 0 && (b == 8'hE0 || b == 8'hF0)) begin
         m_pend.push_back(b);
      end else if (m_pend.size() == 1 && m_pend[0] == 8'hE0 && b == 8'hF0) begin
         m_pend.push_back(b);
      end else begin
         ext = 1'b0;
         brk = 1'b0;
         foreach (m_pend[i]) begin
            if (m_pend[i] == 8'hE0) ext = 1'b1;
            if (m_pend[i] == 8'hF0) brk = 1'b1;
         end
         idx = key_idx(b, ext);
         if (idx >= 0) m_wsad[idx] = !brk;
         m_pend.delete();
      end
   endtask

   task automatic ps2_bit(input logic v);
      @(negedge clk) bus.ps2_data = v;
      repeat (5) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (10) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   // kind: 0 good frame, 1 parity inverted, 2 stop bit low
   task automatic send_frame(input logic [7:0] b, input int kind);
      logic p;
      p = ~^b;
      if (kind == 1) p = ~p;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(p);
      ps2_bit(kind == 2 ? 1'b0 : 1'b1);
      bus.ps2_data = 1'b1;
   endtask

   task automatic send_chk(input logic [7:0] b, input int kind, input string tag);
      int nv0, ne0;
      nv0 = n_valid;
      ne0 = n_err;
      send_frame(b, kind);
      repeat (6) @(negedge clk);
      if (kind == 0) model_byte(b);
      else           m_pend.delete();
      chk({tag, "_valid"}, n_valid - nv0, (kind == 0) ? 1 : 0);
      chk({tag, "_err"},   n_err - ne0,   (kind == 0) ? 0 : 1);
      chk({tag, "_code"},  bus.code,      m_code);
      chk({tag, "_wsad"},  bus.wsad_down, m_wsad);
   endtask

   task automatic do_reset();
      m_wsad = 4'b0000;
      m_code = 8'h00;
      m_pend.delete();
   endtask

   initial begin
      logic [7:0] pool [0:7];
      int r, kind;
      logic [7:0] b;
      pool[0] = 8'h1D; pool[1] = 8'h1B; pool[2] = 8'h1C; pool[3] = 8'h23;
      pool[4] = 8'h75; pool[5] = 8'h72; pool[6] = 8'h6B; pool[7] = 8'h74;
      n_assert = 0; n_fail = 0; n_valid = 0; n_err = 0;
      since_cv = 99; prev_wsad = 4'b0000;
      do_reset();
      rst = 1'b1;
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_wsad", bus.wsad_down, 4'b0000);
      chk("rst_code", bus.code, 8'h00);
      chk("rst_cv",   bus.code_valid, 1'b0);
      chk("rst_fe",   bus.frame_err, 1'b0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      send_chk(8'h1D, 0, "w_make");
      send_chk(8'hF0, 0, "w_brk0");
      send_chk(8'h1D, 0, "w_brk1");

      send_chk(8'hE0, 0, "left_e0");
      send_chk(8'h6B, 0, "left_mk");
      for (int i = 0; i < 3; i++) send_chk(8'h1C, 0, "a_typematic");
      send_chk(8'hE0, 0, "left_b0");
      send_chk(8'hF0, 0, "left_b1");
      send_chk(8'h6B, 0, "left_b2");

      send_chk(8'h23, 1, "d_badpar");
      send_chk(8'h23, 0, "d_make");
      send_chk(8'h1B, 2, "s_badstop");

      // A lone high "start bit" must be ignored without error.
      ps2_bit(1'b1);
      send_chk(8'h1D, 0, "start_hi_w");

      send_chk(8'h1C, 0, "a_make");
      send_chk(8'hAA, 0, "bat_clear");
      send_chk(8'h1C, 0, "post_bat");

`ifdef PS2_TIMEOUT_EN
      begin
         int ne0, nv0;
         ne0 = n_err;
         nv0 = n_valid;
         ps2_bit(1'b0);
         for (int i = 0; i < 4; i++) ps2_bit(1'b1);
         repeat (TO + 20) @(negedge clk);
         m_pend.delete();
         chk("to_err",   n_err - ne0, 1);
         chk("to_valid", n_valid - nv0, 0);
         chk("to_wsad",  bus.wsad_down, m_wsad);
         send_chk(8'h1B, 0, "to_s_make");
      end
`endif

      send_chk(8'hF0, 0, "clr_a0");
      send_chk(8'h1C, 0, "clr_a1");
      send_chk(8'hF0, 0, "clr_s0");
      send_chk(8'h1B, 0, "clr_s1");
      send_chk(8'h1D, 0, "rst_w");
      send_chk(8'h23, 0, "rst_d");
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      #3 rst = 1'b1;
      #1;
      do_reset();
      chk("midrst_wsad", bus.wsad_down, 4'b0000);
      chk("midrst_code", bus.code, 8'h00);
      chk("midrst_cv",   bus.code_valid, 1'b0);
      chk("midrst_fe",   bus.frame_err, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      send_chk(8'h1D, 0, "midrst_w");

      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 15);
         kind = 0;
         if (r < 8)        b = pool[r];
         else if (r == 8)  b = 8'hE0;
         else if (r == 9)  b = 8'hF0;
         else if (r == 10) b = ($urandom_range(0, 1) == 1) ? 8'hAA : 8'hF0;
         else if (r == 11) b = 8'($urandom);
         else if (r == 12) begin b = pool[$urandom_range(0, 7)]; kind = 1; end
         else if (r == 13) begin b = pool[$urandom_range(0, 7)]; kind = 2; end
         else              b = pool[$urandom_range(0, 7)];
         send_chk(b, kind, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
